// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: trigger first, then round-robin between ALU and load writeback.
// Writes leave through a registered stage. Statistics counters exist only when REGFILE_ARB_STATS_EN is defined.
module regfile_write_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int TRIGGER_REG   = 5,
   parameter int TRIGGER_VALUE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req0_valid_i,
   input  logic [ADDRESS_WIDTH-1:0] req0_addr_i,
   input  logic [DATA_WIDTH-1:0]    req0_data_i,
   output logic                     req0_ready_o,
   input  logic                     req1_valid_i,
   input  logic [ADDRESS_WIDTH-1:0] req1_addr_i,
   input  logic [DATA_WIDTH-1:0]    req1_data_i,
   output logic                     req1_ready_o,
   input  logic                     TRIGGER_i,
   output logic                     WE3_o,
   output logic [ADDRESS_WIDTH-1:0] AD3_o,
   output logic [DATA_WIDTH-1:0]    WD3_o,
   output logic                     trig_pending_o,
   output logic [15:0]              grant_cnt0_o,
   output logic [15:0]              grant_cnt1_o,
   output logic [15:0]              stall_cnt_o
);
   localparam logic [ADDRESS_WIDTH-1:0] TRIG_ADDR = ADDRESS_WIDTH'(TRIGGER_REG);
   localparam logic [DATA_WIDTH-1:0]    TRIG_DATA = DATA_WIDTH'(TRIGGER_VALUE);

   // Handshake: reqN transfers in the cycle reqN_valid_i && reqN_ready_o. Ready is derived from
   // valid and is never high without it; the requester holds addr/data while valid && !ready.

   logic                     trig_pending_q;
   logic                     trig_prev_q;
   logic                     last_grant_q;   // 1: requester 1 won the last contention
   logic                     trig_set;
   logic                     gnt_trig;
   logic                     gnt0;
   logic                     gnt1;
   logic                     contention;
   logic                     sel_valid;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]    sel_data;

   // A held TRIGGER_i level counts once; only a new assertion queues another write.
   assign trig_set = TRIGGER_i & ~trig_prev_q;

   always_comb begin
      gnt_trig   = trig_pending_q;
      contention = req0_valid_i & req1_valid_i;
      gnt0       = ~trig_pending_q & req0_valid_i & (~req1_valid_i | last_grant_q);
      gnt1       = ~trig_pending_q & req1_valid_i & (~req0_valid_i | ~last_grant_q);
      sel_valid  = gnt_trig | gnt0 | gnt1;
      sel_addr   = '0;
      sel_data   = '0;
      if (gnt_trig) begin
         sel_addr = TRIG_ADDR;
         sel_data = TRIG_DATA;
      end else if (gnt0) begin
         sel_addr = req0_addr_i;
         sel_data = req0_data_i;
      end else if (gnt1) begin
         sel_addr = req1_addr_i;
         sel_data = req1_data_i;
      end
   end

   assign req0_ready_o   = gnt0;
   assign req1_ready_o   = gnt1;
   assign trig_pending_o = trig_pending_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_pending_q <= 1'b0;
         trig_prev_q    <= 1'b0;
         last_grant_q   <= 1'b1;
      end else begin
         trig_prev_q    <= TRIGGER_i;
         trig_pending_q <= trig_set | (trig_pending_q & ~gnt_trig);
         if (~trig_pending_q & contention) begin
            last_grant_q <= gnt1;
         end
      end
   end

   // Writes to x0 complete the handshake but never reach the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WE3_o <= 1'b0;
         AD3_o <= '0;
         WD3_o <= '0;
      end else begin
         WE3_o <= sel_valid && (sel_addr != '0);
         if (sel_valid && (sel_addr != '0)) begin
            AD3_o <= sel_addr;
            WD3_o <= sel_data;
         end
      end
   end

`ifdef REGFILE_ARB_STATS_EN
   logic [15:0] cnt0_q;
   logic [15:0] cnt1_q;
   logic [15:0] stall_q;
   logic        stall;

   assign stall = (req0_valid_i & ~gnt0) | (req1_valid_i & ~gnt1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         stall_q <= '0;
      end else begin
         if (gnt0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
         if (gnt1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
         if (stall && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      end
   end

   assign grant_cnt0_o = cnt0_q;
   assign grant_cnt1_o = cnt1_q;
   assign stall_cnt_o  = stall_q;
`else
   assign grant_cnt0_o = '0;
   assign grant_cnt1_o = '0;
   assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_regfile_write_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam logic [AW-1:0] TRIG_REG = 5'd5;
   localparam logic [DW-1:0] TRIG_VAL = 32'd1;

   logic          clk;
   logic          rst_n;
   logic          req0_valid_i;
   logic [AW-1:0] req0_addr_i;
   logic [DW-1:0] req0_data_i;
   logic          req0_ready_o;
   logic          req1_valid_i;
   logic [AW-1:0] req1_addr_i;
   logic [DW-1:0] req1_data_i;
   logic          req1_ready_o;
   logic          TRIGGER_i;
   logic          WE3_o;
   logic [AW-1:0] AD3_o;
   logic [DW-1:0] WD3_o;
   logic          trig_pending_o;
   logic [15:0]   grant_cnt0_o;
   logic [15:0]   grant_cnt1_o;
   logic [15:0]   stall_cnt_o;

   regfile_write_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req0_valid_i   (req0_valid_i),
      .req0_addr_i    (req0_addr_i),
      .req0_data_i    (req0_data_i),
      .req0_ready_o   (req0_ready_o),
      .req1_valid_i   (req1_valid_i),
      .req1_addr_i    (req1_addr_i),
      .req1_data_i    (req1_data_i),
      .req1_ready_o   (req1_ready_o),
      .TRIGGER_i      (TRIGGER_i),
      .WE3_o          (WE3_o),
      .AD3_o          (AD3_o),
      .WD3_o          (WD3_o),
      .trig_pending_o (trig_pending_o),
      .grant_cnt0_o   (grant_cnt0_o),
      .grant_cnt1_o   (grant_cnt1_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic        m_pending;
   logic        m_prev_trig;
   logic        m_last;        // requester that won the most recent contention
   int unsigned m_c0, m_c1, m_stall;

   // Per-cycle expected/observed values captured by run_cycle
   logic [2:0]       exp_hs, obs_hs;   // {ready0, ready1, trig_pending}
   logic             exp_we, obs_we;
   logic [AW+DW-1:0] exp_aw, obs_aw;   // {addr, data}

   task automatic model_reset();
      m_pending   = 1'b0;
      m_prev_trig = 1'b0;
      m_last      = 1'b1;
      m_c0        = 0;
      m_c1        = 0;
      m_stall     = 0;
   endtask

   task automatic do_reset();
      req0_valid_i = 1'b0;
      req0_addr_i  = '0;
      req0_data_i  = '0;
      req1_valid_i = 1'b0;
      req1_addr_i  = '0;
      req1_data_i  = '0;
      TRIGGER_i    = 1'b0;
      rst_n        = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Driver: applies one cycle of inputs (called 1 time unit after a rising edge), records
   // observed handshake and write, and advances the reference model.
   task automatic run_cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                            input logic trig);
      logic          g0, g1, gt;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      req0_valid_i = v0;
      req0_addr_i  = a0;
      req0_data_i  = d0;
      req1_valid_i = v1;
      req1_addr_i  = a1;
      req1_data_i  = d1;
      TRIGGER_i    = trig;
      #2;
      gt = m_pending;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!m_pending) begin
         if (v0 && v1) begin
            g0     = (m_last == 1'b1);
            g1     = !g0;
            m_last = g1;
         end else begin
            g0 = v0;
            g1 = v1;
         end
      end
      exp_hs = {g0, g1, m_pending};
      obs_hs = {req0_ready_o, req1_ready_o, trig_pending_o};
      if (g0 && m_c0 < 65535) m_c0++;
      if (g1 && m_c1 < 65535) m_c1++;
      if (((v0 && !g0) || (v1 && !g1)) && m_stall < 65535) m_stall++;
      wa = gt ? TRIG_REG : g0 ? a0 : g1 ? a1 : '0;
      wd = gt ? TRIG_VAL : g0 ? d0 : g1 ? d1 : '0;
      exp_we = (gt || g0 || g1) && (wa != '0);
      exp_aw = {wa, wd};
      m_pending   = (m_pending && !gt) || (trig && !m_prev_trig);
      m_prev_trig = trig;
      @(posedge clk);
      #1;
      obs_we = WE3_o;
      obs_aw = {AD3_o, WD3_o};
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({WE3_o, AD3_o, WD3_o, trig_pending_o, req0_ready_o, req1_ready_o} !== '0)
         $display("FAIL reset_outputs got we=%b ad=%h wd=%h tp=%b exp all 0", WE3_o, AD3_o, WD3_o, trig_pending_o);
      else n_pass++;
      n_checks++;
      if ({grant_cnt0_o, grant_cnt1_o, stall_cnt_o} !== 48'h0)
         $display("FAIL reset_counters got %h %h %h exp 0", grant_cnt0_o, grant_cnt1_o, stall_cnt_o);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
         n_checks++;
         if ({obs_we, obs_aw, obs_hs} !== '0)
            $display("FAIL reset_idle cyc=%0d got we=%b aw=%h hs=%b exp all 0", i, obs_we, obs_aw, obs_hs);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      run_cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
      n_checks++;
      if (obs_hs !== 3'b100) $display("FAIL single_ready got %b exp 100", obs_hs);
      else n_pass++;
      n_checks++;
      if (obs_we !== 1'b1 || obs_aw !== {5'd3, 32'hDEADBEEF})
         $display("FAIL single_write got we=%b aw=%h exp we=1 aw=%h", obs_we, obs_aw, {5'd3, 32'hDEADBEEF});
      else n_pass++;
      run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      n_checks++;
      if (obs_we !== 1'b0) $display("FAIL single_after got we=%b exp 0", obs_we);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
         n_checks++;
         if (obs_hs !== ((i % 2 == 0) ? 3'b100 : 3'b010) || obs_hs !== exp_hs)
            $display("FAIL rr_grant cyc=%0d got %b exp %b", i, obs_hs, exp_hs);
         else n_pass++;
         n_checks++;
         if (obs_we !== 1'b1 || obs_aw !== exp_aw)
            $display("FAIL rr_write cyc=%0d got we=%b aw=%h exp we=1 aw=%h", i, obs_we, obs_aw, exp_aw);
         else n_pass++;
      end
      run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_trigger();
      int          trig_writes;
      logic [13:0] trig_pat;
      trig_writes = 0;
      trig_pat    = 14'b00000000000111;
      for (int i = 0; i < 8; i++) begin
         run_cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, trig_pat[i]);
         if (obs_we && obs_aw == {TRIG_REG, TRIG_VAL}) trig_writes++;
         n_checks++;
         if (obs_hs !== exp_hs)
            $display("FAIL trig_handshake cyc=%0d got %b exp %b", i, obs_hs, exp_hs);
         else n_pass++;
         n_checks++;
         if (obs_we !== exp_we || (exp_we && obs_aw !== exp_aw))
            $display("FAIL trig_write cyc=%0d got we=%b aw=%h exp we=%b aw=%h", i, obs_we, obs_aw, exp_we, exp_aw);
         else n_pass++;
      end
      n_checks++;
      if (trig_writes != 1) $display("FAIL trig_once got %0d writes exp 1", trig_writes);
      else n_pass++;
      run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_x0();
      do_reset();
      run_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
      n_checks++;
      if (obs_hs !== 3'b010) $display("FAIL x0_ready got %b exp 010", obs_hs);
      else n_pass++;
      n_checks++;
      if (obs_we !== 1'b0) $display("FAIL x0_suppress got we=%b exp 0", obs_we);
      else n_pass++;
`ifdef REGFILE_ARB_STATS_EN
      n_checks++;
      if (grant_cnt1_o !== 16'd1) $display("FAIL x0_grant_cnt1 got %0d exp 1", grant_cnt1_o);
      else n_pass++;
`endif
   endtask

   task automatic test_random();
      logic          h0v, h1v, tr;
      logic [AW-1:0] h0a, h1a;
      logic [DW-1:0] h0d, h1d;
      int            w0, w1, t0, t1;
      h0v = 1'b0; h1v = 1'b0; h0a = '0; h1a = '0; h0d = '0; h1d = '0;
      w0 = 0; w1 = 0; t0 = 0; t1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (!h0v && $urandom_range(0, 99) < 60) begin
            h0v = 1'b1; h0a = AW'($urandom_range(0, 31)); h0d = $urandom;
         end
         if (!h1v && $urandom_range(0, 99) < 60) begin
            h1v = 1'b1; h1a = AW'($urandom_range(0, 31)); h1d = $urandom;
         end
         tr = ($urandom_range(0, 99) < 12);
         run_cycle(h0v, h0a, h0d, h1v, h1a, h1d, tr);
         n_checks++;
         if (obs_hs !== exp_hs)
            $display("FAIL rand_handshake cyc=%0d got %b exp %b", i, obs_hs, exp_hs);
         else n_pass++;
         n_checks++;
         if (obs_we !== exp_we || (exp_we && obs_aw !== exp_aw))
            $display("FAIL rand_write cyc=%0d got we=%b aw=%h exp we=%b aw=%h", i, obs_we, obs_aw, exp_we, exp_aw);
         else n_pass++;
         if (h0v) begin
            w0++;
            if (exp_hs[0]) t0++;
            if (obs_hs[2]) begin
               n_checks++;
               if (w0 > 2 + t0) $display("FAIL starve0 cyc=%0d waited %0d exp <= %0d", i, w0, 2 + t0);
               else n_pass++;
               w0 = 0; t0 = 0;
            end
         end
         if (h1v) begin
            w1++;
            if (exp_hs[0]) t1++;
            if (obs_hs[1]) begin
               n_checks++;
               if (w1 > 2 + t1) $display("FAIL starve1 cyc=%0d waited %0d exp <= %0d", i, w1, 2 + t1);
               else n_pass++;
               w1 = 0; t1 = 0;
            end
         end
         if (exp_hs[2]) h0v = 1'b0;
         if (exp_hs[1]) h1v = 1'b0;
      end
      n_checks++;
`ifdef REGFILE_ARB_STATS_EN
      if ({grant_cnt0_o, grant_cnt1_o, stall_cnt_o} !== {m_c0[15:0], m_c1[15:0], m_stall[15:0]})
         $display("FAIL rand_counters got %0d %0d %0d exp %0d %0d %0d", grant_cnt0_o, grant_cnt1_o,
                  stall_cnt_o, m_c0, m_c1, m_stall);
      else n_pass++;
`else
      if ({grant_cnt0_o, grant_cnt1_o, stall_cnt_o} !== 48'h0)
         $display("FAIL rand_counters got %0d %0d %0d exp 0 0 0", grant_cnt0_o, grant_cnt1_o, stall_cnt_o);
      else n_pass++;
`endif
      run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      run_cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, 1'b1);
      n_checks++;
      if (trig_pending_o !== 1'b1 || WE3_o !== 1'b1 || AD3_o !== 5'd7)
         $display("FAIL midrst_setup got tp=%b we=%b ad=%h exp tp=1 we=1 ad=07", trig_pending_o, WE3_o, AD3_o);
      else n_pass++;
      req0_valid_i = 1'b1;
      req0_addr_i  = 5'd9;
      req0_data_i  = 32'h99;
      TRIGGER_i    = 1'b0;
      #2;
      req0_valid_i = 1'b0;
      rst_n        = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({WE3_o, AD3_o, WD3_o, trig_pending_o} !== '0)
         $display("FAIL midrst_async got we=%b ad=%h wd=%h tp=%b exp all 0", WE3_o, AD3_o, WD3_o, trig_pending_o);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
         n_checks++;
         if (obs_we !== 1'b0 || obs_hs !== 3'b000)
            $display("FAIL midrst_after cyc=%0d got we=%b hs=%b exp we=0 hs=000", i, obs_we, obs_hs);
         else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_trigger();
      test_x0();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
